lut_read_arbiter: RTL and testbench

- Shares the single read port of the GELU lookup-table SRAM (32-bit words, positive half in [15:0], negative half in [31:16]) between N gelu lanes.
- Each lane posts one lookup (12-bit address plus sign). The block captures it, serves the lanes round-robin (one SRAM read per cycle) and returns the selected 16-bit half to the requesting lane.
- Replaces the fixed 5-state LUT sequencer in the accelerator top, so lanes may request at any time and in any order.

---
 rtl/lut_read_arbiter_if.sv | 26 ++
 rtl/lut_read_arbiter.sv | 129 ++++++++++++
 tb/tb_lut_read_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lut_read_arbiter_if.sv
// Lane-side bundle of the GELU LUT read arbiter: per-lane lookup requests
// and the shared response bus returned to the lanes.
interface lut_read_arbiter_if #(
    parameter int N  = 4,
    parameter int AW = 12,
    parameter int DW = 32
);
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_sign;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [DW/2-1:0]   rsp_data;

    // Lane side drives requests and receives results.
    modport master (
        output req_valid, req_addr, req_sign,
        input  req_ready, rsp_valid, rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_addr, req_sign,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/lut_read_arbiter.sv
// Round-robin sharing of the single GELU LUT SRAM read port between N lanes:
// capture one lookup per lane, issue one read per cycle, return the signed half.
module lut_read_arbiter #(
    parameter int N  = 4,
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    lut_read_arbiter_if.slave    lanes,
    output logic                 lut_rd_en,
    output logic [AW-1:0]        lut_raddr,
    input  logic [DW-1:0]        lut_rdata,
    output logic                 idle,
    output logic                 batch_done
);
    localparam int PW = $clog2(N);
    localparam int HW = DW / 2;

    logic [N-1:0]    r_pending;
    logic [AW-1:0]   r_addr_q [N];
    logic [N-1:0]    r_sign_q;
    logic [PW-1:0]   r_rr_ptr;

    logic            r_lut_rd_en;
    logic [AW-1:0]   r_lut_raddr;
    logic [PW-1:0]   r_rd_lane;
    logic            r_rd_sign;

    logic            r_tag_valid;
    logic [PW-1:0]   r_tag_lane;
    logic            r_tag_sign;

    logic [N-1:0]    r_rsp_valid;
    logic [HW-1:0]   r_rsp_data;
    logic            r_idle_d;

    logic [N-1:0]    w_capture;
    logic            w_grant_any;
    logic [PW-1:0]   w_grant_lane;
    logic [N-1:0]    w_grant_onehot;
    logic [PW-1:0]   w_rr_next;
    logic [PW:0]     w_sum;
    logic [PW-1:0]   w_idx;
    logic            w_idle;

    // A lane holding a pending lookup is deaf to further requests.
    assign w_capture       = lanes.req_valid & ~r_pending;
    assign lanes.req_ready = ~r_pending;

    // NOTE: every variable is given a default before the search loop so that
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_grant_any  = 1'b0;
        w_grant_lane = '0;
        w_sum        = '0;
        w_idx        = '0;
        for (int off = 0; off < N; off++) begin
            w_sum = {1'b0, r_rr_ptr} + (PW+1)'(off);
            if (w_sum >= (PW+1)'(N)) begin
                w_sum = w_sum - (PW+1)'(N);
            end
            w_idx = w_sum[PW-1:0];
            if (!w_grant_any && r_pending[w_idx]) begin
                w_grant_any  = 1'b1;
                w_grant_lane = w_idx;
            end
        end
    end

    assign w_grant_onehot = w_grant_any ? (N'(1) << w_grant_lane) : '0;
    assign w_rr_next      = (w_grant_lane == PW'(N - 1)) ? '0 : w_grant_lane + PW'(1);

    assign w_idle = ~|r_pending & ~r_lut_rd_en & ~r_tag_valid & ~|r_rsp_valid;

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_rr_ptr    <= '0;
            r_lut_rd_en <= 1'b0;
            r_lut_raddr <= '0;
            r_tag_valid <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_idle_d    <= 1'b1;
        end else begin
            r_pending   <= (r_pending & ~w_grant_onehot) | w_capture;
            r_lut_rd_en <= w_grant_any;
            if (w_grant_any) begin
                r_lut_raddr <= r_addr_q[w_grant_lane];
                r_rr_ptr    <= w_rr_next;
            end
            r_tag_valid <= r_lut_rd_en;
            if (r_tag_valid) begin
                r_rsp_valid <= N'(1) << r_tag_lane;
                r_rsp_data  <= r_tag_sign ? lut_rdata[DW-1:HW] : lut_rdata[HW-1:0];
            end else begin
                r_rsp_valid <= '0;
            end
            r_idle_d <= w_idle;
        end
    end

    // NOTE: payload and tag registers carry no reset; they are only consumed
    // when the matching pending/valid bit is set, and that bit is reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (w_capture[i]) begin
                r_addr_q[i] <= lanes.req_addr[i*AW +: AW];
                r_sign_q[i] <= lanes.req_sign[i];
            end
        end
        if (w_grant_any) begin
            r_rd_lane <= w_grant_lane;
            r_rd_sign <= r_sign_q[w_grant_lane];
        end
        r_tag_lane <= r_rd_lane;
        r_tag_sign <= r_rd_sign;
    end

    assign lut_rd_en       = r_lut_rd_en;
    assign lut_raddr       = r_lut_raddr;
    assign lanes.rsp_valid = r_rsp_valid;
    assign lanes.rsp_data  = r_rsp_data;
    assign idle            = w_idle;
    assign batch_done      = w_idle & ~r_idle_d;
endmodule

// File: tb/tb_lut_read_arbiter.sv
// Directed bench for lut_read_arbiter: a registered SRAM model feeds the
// read port, and each scenario task checks its own hand-computed results.
module tb_lut_read_arbiter;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          lut_rd_en;
    logic [AW-1:0] lut_raddr;
    logic [DW-1:0] lut_rdata;
    logic          idle;
    logic          batch_done;

    int n_checks = 0;
    int n_fails  = 0;

    lut_read_arbiter_if #(.N(N), .AW(AW), .DW(DW)) lanes_if ();

    lut_read_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .lanes      (lanes_if),
        .lut_rd_en  (lut_rd_en),
        .lut_raddr  (lut_raddr),
        .lut_rdata  (lut_rdata),
        .idle       (idle),
        .batch_done (batch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Halves are distinguishable: upper = {C,addr}, lower = {3,addr}.
    function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
        if (a == 12'h05A) return 32'hBEEF_1234;
        return {4'hC, a, 4'h3, a};
    endfunction

    always @(posedge clk) begin
        if (lut_rd_en) lut_rdata <= sram_word(lut_raddr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [AW-1:0] a, input logic s);
        lanes_if.req_addr[i*AW +: AW] = a;
        lanes_if.req_sign[i]          = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lanes_if.req_valid = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lanes_if.req_valid = '0;
        tick();
        tick();
        n_checks++; if (lanes_if.req_ready !== 4'b1111) begin n_fails++; $display("FAIL reset_ready got %b want 1111", lanes_if.req_ready); end
        n_checks++; if (lut_rd_en !== 1'b0) begin n_fails++; $display("FAIL reset_rd_en got %b want 0", lut_rd_en); end
        n_checks++; if (lut_raddr !== 12'h000) begin n_fails++; $display("FAIL reset_raddr got %h want 000", lut_raddr); end
        n_checks++; if (lanes_if.rsp_valid !== 4'b0000) begin n_fails++; $display("FAIL reset_rsp_valid got %b want 0000", lanes_if.rsp_valid); end
        n_checks++; if (lanes_if.rsp_data !== 16'h0000) begin n_fails++; $display("FAIL reset_rsp_data got %h want 0000", lanes_if.rsp_data); end
        n_checks++; if (idle !== 1'b1) begin n_fails++; $display("FAIL reset_idle got %b want 1", idle); end
        n_checks++; if (batch_done !== 1'b0) begin n_fails++; $display("FAIL reset_batch_done got %b want 0", batch_done); end
        rst = 1'b0;
        tick();
        n_checks++; if (batch_done !== 1'b0 || idle !== 1'b1) begin n_fails++; $display("FAIL post_reset_idle got idle=%b bd=%b want 1/0", idle, batch_done); end
    endtask

    task automatic test_single_lane(input logic sign, input logic [15:0] exp_data);
        set_lane(2, 12'h05A, sign);
        lanes_if.req_valid = 4'b0100;
        tick(); // accept
        lanes_if.req_valid = '0;
        n_checks++; if (lanes_if.req_ready !== 4'b1011) begin n_fails++; $display("FAIL single_ready got %b want 1011", lanes_if.req_ready); end
        tick(); // grant
        n_checks++; if (lut_rd_en !== 1'b1 || lut_raddr !== 12'h05A) begin n_fails++; $display("FAIL single_grant got en=%b addr=%h want 1/05a", lut_rd_en, lut_raddr); end
        tick(); // SRAM read
        n_checks++; if (lut_rd_en !== 1'b0 || lanes_if.rsp_valid !== 4'b0000) begin n_fails++; $display("FAIL single_gap got en=%b rsp=%b want 0/0000", lut_rd_en, lanes_if.rsp_valid); end
        tick(); // response, 3 edges after accept
        n_checks++; if (lanes_if.rsp_valid !== 4'b0100) begin n_fails++; $display("FAIL single_rsp_valid got %b want 0100", lanes_if.rsp_valid); end
        n_checks++; if (lanes_if.rsp_data !== exp_data) begin n_fails++; $display("FAIL single_rsp_data got %h want %h", lanes_if.rsp_data, exp_data); end
        n_checks++; if (idle !== 1'b0) begin n_fails++; $display("FAIL single_busy got idle=%b want 0", idle); end
        tick();
        n_checks++; if (lanes_if.rsp_valid !== 4'b0000 || idle !== 1'b1 || batch_done !== 1'b1) begin n_fails++; $display("FAIL single_done got rsp=%b idle=%b bd=%b want 0000/1/1", lanes_if.rsp_valid, idle, batch_done); end
        tick();
        n_checks++; if (batch_done !== 1'b0) begin n_fails++; $display("FAIL single_bd_pulse got %b want 0", batch_done); end
    endtask

    task automatic test_all_lanes();
        do_reset();
        for (int i = 0; i < N; i++) set_lane(i, 12'h010 + 12'(i), 1'b0);
        lanes_if.req_valid = 4'b1111;
        tick();
        lanes_if.req_valid = '0;
        n_checks++; if (lanes_if.req_ready !== 4'b0000) begin n_fails++; $display("FAIL all_ready got %b want 0000", lanes_if.req_ready); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k <= 4) begin
                n_checks++; if (lut_rd_en !== 1'b1 || lut_raddr !== 12'h010 + 12'(k-1)) begin n_fails++; $display("FAIL all_grant%0d got en=%b addr=%h want 1/%h", k, lut_rd_en, lut_raddr, 12'h010 + 12'(k-1)); end
            end else begin
                n_checks++; if (lut_rd_en !== 1'b0) begin n_fails++; $display("FAIL all_rd_off%0d got %b want 0", k, lut_rd_en); end
            end
            if (k >= 3) begin
                n_checks++; if (lanes_if.rsp_valid !== (4'b0001 << (k-3)) || lanes_if.rsp_data !== 16'h3010 + 16'(k-3)) begin n_fails++; $display("FAIL all_rsp%0d got %b/%h want %b/%h", k, lanes_if.rsp_valid, lanes_if.rsp_data, 4'b0001 << (k-3), 16'h3010 + 16'(k-3)); end
            end
        end
        tick();
        n_checks++; if (idle !== 1'b1 || batch_done !== 1'b1) begin n_fails++; $display("FAIL all_done got idle=%b bd=%b want 1/1", idle, batch_done); end
    endtask

    // Pointer is 0 here; lane 0 must win first, then yield to lane 3.
    task automatic test_fairness();
        set_lane(0, 12'h100, 1'b0);
        set_lane(3, 12'h300, 1'b1);
        lanes_if.req_valid = 4'b1001;
        tick();
        lanes_if.req_valid = 4'b0001;
        tick();
        n_checks++; if (lut_rd_en !== 1'b1 || lut_raddr !== 12'h100) begin n_fails++; $display("FAIL fair_g0 got en=%b addr=%h want 1/100", lut_rd_en, lut_raddr); end
        tick();
        n_checks++; if (lut_rd_en !== 1'b1 || lut_raddr !== 12'h300) begin n_fails++; $display("FAIL fair_g1 got en=%b addr=%h want 1/300", lut_rd_en, lut_raddr); end
        lanes_if.req_valid = '0;
        tick();
        n_checks++; if (lut_rd_en !== 1'b1 || lut_raddr !== 12'h100) begin n_fails++; $display("FAIL fair_g2 got en=%b addr=%h want 1/100", lut_rd_en, lut_raddr); end
        n_checks++; if (lanes_if.rsp_valid !== 4'b0001 || lanes_if.rsp_data !== 16'h3100) begin n_fails++; $display("FAIL fair_r0 got %b/%h want 0001/3100", lanes_if.rsp_valid, lanes_if.rsp_data); end
        tick();
        n_checks++; if (lut_rd_en !== 1'b0) begin n_fails++; $display("FAIL fair_rd_off got %b want 0", lut_rd_en); end
        n_checks++; if (lanes_if.rsp_valid !== 4'b1000 || lanes_if.rsp_data !== 16'hC300) begin n_fails++; $display("FAIL fair_r1 got %b/%h want 1000/c300", lanes_if.rsp_valid, lanes_if.rsp_data); end
        tick();
        n_checks++; if (lanes_if.rsp_valid !== 4'b0001 || lanes_if.rsp_data !== 16'h3100) begin n_fails++; $display("FAIL fair_r2 got %b/%h want 0001/3100", lanes_if.rsp_valid, lanes_if.rsp_data); end
        tick();
        n_checks++; if (idle !== 1'b1) begin n_fails++; $display("FAIL fair_idle got %b want 1", idle); end
    endtask

    task automatic test_back_pressure();
        set_lane(1, 12'h021, 1'b0);
        lanes_if.req_valid = 4'b0010;
        tick();
        set_lane(1, 12'h0AA, 1'b1);
        n_checks++; if (lanes_if.req_ready[1] !== 1'b0) begin n_fails++; $display("FAIL bp_ready got %b want 0", lanes_if.req_ready[1]); end
        tick();
        n_checks++; if (lut_rd_en !== 1'b1 || lut_raddr !== 12'h021) begin n_fails++; $display("FAIL bp_grant got en=%b addr=%h want 1/021", lut_rd_en, lut_raddr); end
        n_checks++; if (lanes_if.req_ready[1] !== 1'b1) begin n_fails++; $display("FAIL bp_ready_back got %b want 1", lanes_if.req_ready[1]); end
        lanes_if.req_valid = '0;
        tick();
        n_checks++; if (lut_rd_en !== 1'b0 || lut_raddr !== 12'h021) begin n_fails++; $display("FAIL bp_no_second got en=%b addr=%h want 0/021", lut_rd_en, lut_raddr); end
        tick();
        n_checks++; if (lanes_if.rsp_valid !== 4'b0010 || lanes_if.rsp_data !== 16'h3021) begin n_fails++; $display("FAIL bp_rsp got %b/%h want 0010/3021", lanes_if.rsp_valid, lanes_if.rsp_data); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        for (int i = 0; i < N; i++) set_lane(i, 12'h020 + 12'(i), 1'b0);
        lanes_if.req_valid = 4'b1111;
        tick();
        lanes_if.req_valid = '0;
        tick();
        n_checks++; if (lut_rd_en !== 1'b1 || lut_raddr !== 12'h020) begin n_fails++; $display("FAIL rmid_grant got en=%b addr=%h want 1/020", lut_rd_en, lut_raddr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (lanes_if.req_ready !== 4'b1111) begin n_fails++; $display("FAIL rmid_ready got %b want 1111", lanes_if.req_ready); end
        n_checks++; if (idle !== 1'b1 || batch_done !== 1'b0) begin n_fails++; $display("FAIL rmid_idle got idle=%b bd=%b want 1/0", idle, batch_done); end
        n_checks++; if (lut_rd_en !== 1'b0 || lanes_if.rsp_valid !== 4'b0000) begin n_fails++; $display("FAIL rmid_clear got en=%b rsp=%b want 0/0000", lut_rd_en, lanes_if.rsp_valid); end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++; if (lut_rd_en !== 1'b0 || lanes_if.rsp_valid !== 4'b0000) begin n_fails++; $display("FAIL rmid_quiet%0d got en=%b rsp=%b want 0/0000", k, lut_rd_en, lanes_if.rsp_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        lut_rdata          = '0;
        lanes_if.req_valid = '0;
        lanes_if.req_addr  = '0;
        lanes_if.req_sign  = '0;
        test_reset();
        test_single_lane(1'b0, 16'h1234);
        test_single_lane(1'b1, 16'hBEEF);
        test_all_lanes();
        test_fairness();
        test_back_pressure();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
